debug_frame_writer: RTL and testbench
=====================================

# debug_frame_writer

MIPS-side responder of the MicroBlaze debug link. It waits for a request-select pulse from the debug interface and snapshots the addressed source: GPR, PC, data memory, instruction memory or one pipeline latch group. It then streams that source as consecutive 32-bit frames on the return path and closes each response with a one-cycle end-of-data (EoD) marker. It sits between the pipeline and register/memory debug ports on one side and the debug interface's `i_frame_from_mips` / `i_eod` inputs on the other.

## Interface
- `NB_CONTROL_FRAME`, 32: frame width.
- `NB_REG`, 32: GPR/PC/memory word width; equals `NB_CONTROL_FRAME`.
- `NB_LATCH`, 96: width of every latch-group vector. Must be a multiple of `NB_CONTROL_FRAME`. Derived `N_WORDS = NB_LATCH/NB_CONTROL_FRAME` (3).
- `NB_SELECT`, 6: request-select width.

Ports (clock and reset first):
- `i_clock`, in, 1: clock. All state updates on the rising edge.
- `i_reset`, in, 1: synchronous, active-high.
- `i_request_select`, in, 6: request code. It is valid for exactly one cycle. `6'b111111` means no request.
- `o_reg_addr`, out, 5: GPR debug read address. Equals `i_request_select[4:0]`, combinational.
- `i_reg_data`, in, 32: GPR debug read data, asynchronous read.
- `i_pc`, in, 32: current PC.
- `i_mem_data`, in, 32: data-memory debug read data. Synchronous read: valid the cycle after the address.
- `i_instr_mem_data`, in, 32: instruction-memory debug read data. Synchronous read, same timing as `i_mem_data`.
- `i_latch_{fetch,deco,exec,mem}_{data,ctrl}`, in, `NB_LATCH` each: eight flattened latch groups. MSB-first word order.
- `o_frame`, out, 32: response word.
- `o_eod`, out, 1: end-of-data strobe.
- `o_busy`, out, 1: high whenever the state is not IDLE.

## Operation
Request codes and word counts (N):
- `0_rrrrr`: GPR r; N=1.
- `100000`: data memory; N=1.
- `100001`: instruction memory; N=1.
- `100010`: PC; N=1.
- `100100`..`101011`: latch groups in this order, N=`N_WORDS`:
  - `100100` fetch data, `100101` fetch ctrl
  - `100110` deco data, `100111` deco ctrl
  - `101000` exec data, `101001` exec ctrl
  - `101010` mem data, `101011` mem ctrl
- Any other code except `111111`: invalid; N=0.

FSM states:
- **IDLE:**
  - A request code other than `111111` latches the code and sets `word_cnt` := 0.
  - In the same cycle, the source is snapshotted into the 96-bit shift register `snap`:
    - GPR or PC: value placed in the top word.
    - Latch group: full vector.
  - Memory sources are not snapshotted; they are read live in SEND.
  - Next state: SEND if N>0, otherwise EOD.
- **SEND:**
  - `o_frame` = `i_mem_data` or `i_instr_mem_data` for memory requests; otherwise `snap[95:64]`.
  - Each cycle: `snap` shifts left by 32 and `word_cnt` increments.
  - When `word_cnt == N-1`, next state is EOD.
- **EOD:** `o_eod`=1, `o_frame`=0, for one cycle. Next state is IDLE.

Rules:
- `i_request_select` is ignored outside IDLE, including in EOD. The debug interface never issues a request while `o_busy`=1.
- `o_frame`=0 in IDLE.
- `word_cnt` is 2 bits and never wraps, because N ≤ 3.
- Snapshot coherence: latch inputs changing after the request cycle do not affect the emitted words.

Reset values: `o_frame`=0, `o_eod`=0, `o_busy`=0, state IDLE, `snap`=0, `word_cnt`=0. A reset mid-burst aborts the response; no EoD is emitted.

## Timing
- Request pulse in cycle T:
  - Word k appears on `o_frame` in cycle T+1+k.
  - `o_eod` is high in cycle T+1+N.
  - The block is back in IDLE at T+2+N.
- Invalid request: `o_eod` at T+1 with no words. The debug interface then counts 0 words and answers NOK.
- Memory: the debug interface drives the address in cycle T, and the memory returns data at T+1. That is exactly the single SEND cycle, so the data is passed through combinationally.
- Maximum occupancy: 5 cycles (IDLE accept, 3×SEND, EOD).
- `o_frame`, `o_eod` and `o_busy` are driven from registered state plus the input mux. There is no combinational path from `i_request_select` to `o_eod`.

## Structure
- Shared header `debug_defs.vh`, included by both ends of the link:
  - Request-select codes and the idle code `6'b111111`.
  - `NB_CONTROL_FRAME`.
  - FSM state encodings.
- Single flat module; no sub-module. The per-code source/N decode is one combinational function inside the module.

## Test plan
1. **Reset:** hold `i_reset` 2 cycles → `o_frame`=0, `o_eod`=0, `o_busy`=0.
2. **GPR:** `i_request_select`=`6'b000101` at T, `i_reg_data`=`32'hDEADBEEF` → `o_reg_addr`=5 at T; `o_frame`=`32'hDEADBEEF` at T+1; `o_eod`=1 at T+2; `o_busy` low at T+3.
3. **Latch group:** select `6'b101000`, `i_latch_exec_data`=`96'h11111111_22222222_33333333`; change the input at T+1 → frames `11111111`, `22222222`, `33333333` at T+1..T+3; `o_eod` at T+4.
4. **Data memory:** select `6'b100000`; `i_mem_data`=`32'hCAFE0001` only at T+1 → `o_frame`=`32'hCAFE0001` at T+1; `o_eod` at T+2.
5. **Invalid code:** select `6'b101100` → `o_eod`=1 at T+1, `o_frame`=0; IDLE at T+2.
6. **Abort and ignore:**
   - Latch request at T, second request (`6'b100010`) at T+1 → second request ignored.
   - `i_reset` at T+2 → `o_frame`=0 and no `o_eod` from T+3 on.
   - A fresh PC request afterwards returns `i_pc` normally.

Source files
------------

// File: rtl/debug_frame_writer_pkg.sv
// Shared definitions for both ends of the MicroBlaze debug link:
// request-select codes, the frame width and the responder FSM encoding.
package debug_frame_writer_pkg;

  localparam int DBG_NB_CONTROL_FRAME = 32;

  localparam logic [5:0] SEL_IDLE       = 6'b111111;
  localparam logic [5:0] SEL_DMEM       = 6'b100000;
  localparam logic [5:0] SEL_IMEM       = 6'b100001;
  localparam logic [5:0] SEL_PC         = 6'b100010;
  localparam logic [5:0] SEL_FETCH_DATA = 6'b100100;
  localparam logic [5:0] SEL_FETCH_CTRL = 6'b100101;
  localparam logic [5:0] SEL_DECO_DATA  = 6'b100110;
  localparam logic [5:0] SEL_DECO_CTRL  = 6'b100111;
  localparam logic [5:0] SEL_EXEC_DATA  = 6'b101000;
  localparam logic [5:0] SEL_EXEC_CTRL  = 6'b101001;
  localparam logic [5:0] SEL_MEM_DATA   = 6'b101010;
  localparam logic [5:0] SEL_MEM_CTRL   = 6'b101011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_EOD  = 2'd2;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_GPR,
    SRC_PC,
    SRC_DMEM,
    SRC_IMEM,
    SRC_LATCH
  } src_e;

  typedef struct packed {
    src_e       src;
    logic [1:0] n;
  } req_info_t;

endpackage

// File: rtl/debug_frame_writer.sv
// MIPS-side responder of the debug link: snapshots the addressed source on a
// request pulse, streams it as 32-bit frames and closes with a one-cycle EoD.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a request code other than 6'b111111
// SEND    | one frame per cycle; snap shifts left, word_cnt counts up
// EOD     | o_eod high for one cycle with o_frame = 0, then IDLE
module debug_frame_writer
  import debug_frame_writer_pkg::*;
#(
  parameter int NB_CONTROL_FRAME = DBG_NB_CONTROL_FRAME,
  parameter int NB_REG           = 32,
  parameter int NB_LATCH         = 96,
  parameter int NB_SELECT        = 6
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [NB_SELECT-1:0]        i_request_select,
  output logic [4:0]                  o_reg_addr,
  input  logic [NB_REG-1:0]           i_reg_data,
  input  logic [NB_REG-1:0]           i_pc,
  input  logic [NB_REG-1:0]           i_mem_data,
  input  logic [NB_REG-1:0]           i_instr_mem_data,
  input  logic [NB_LATCH-1:0]         i_latch_fetch_data,
  input  logic [NB_LATCH-1:0]         i_latch_fetch_ctrl,
  input  logic [NB_LATCH-1:0]         i_latch_deco_data,
  input  logic [NB_LATCH-1:0]         i_latch_deco_ctrl,
  input  logic [NB_LATCH-1:0]         i_latch_exec_data,
  input  logic [NB_LATCH-1:0]         i_latch_exec_ctrl,
  input  logic [NB_LATCH-1:0]         i_latch_mem_data,
  input  logic [NB_LATCH-1:0]         i_latch_mem_ctrl,
  output logic [NB_CONTROL_FRAME-1:0] o_frame,
  output logic                        o_eod,
  output logic                        o_busy
);

  localparam int         N_WORDS     = NB_LATCH / NB_CONTROL_FRAME;
  localparam logic [1:0] N_WORDS_CNT = 2'(N_WORDS);

  logic [1:0]           state_q, state_d;
  logic [NB_SELECT-1:0] sel_q, sel_d;
  logic [NB_LATCH-1:0]  snap_q, snap_d;
  logic [1:0]           word_cnt_q, word_cnt_d;
  logic [NB_LATCH-1:0]  latch_vec;
  req_info_t            req_new;
  req_info_t            req_cur;

  function automatic req_info_t decode(input logic [NB_SELECT-1:0] sel);
    req_info_t r;
    r.src = SRC_NONE;
    r.n   = 2'd0;
    if (sel[NB_SELECT-1] == 1'b0) begin
      r.src = SRC_GPR;
      r.n   = 2'd1;
    end else if (sel == SEL_DMEM) begin
      r.src = SRC_DMEM;
      r.n   = 2'd1;
    end else if (sel == SEL_IMEM) begin
      r.src = SRC_IMEM;
      r.n   = 2'd1;
    end else if (sel == SEL_PC) begin
      r.src = SRC_PC;
      r.n   = 2'd1;
    end else if (sel >= SEL_FETCH_DATA && sel <= SEL_MEM_CTRL) begin
      r.src = SRC_LATCH;
      r.n   = N_WORDS_CNT;
    end
    return r;
  endfunction

  assign o_reg_addr = i_request_select[4:0];
  assign req_new    = decode(i_request_select);
  assign req_cur    = decode(sel_q);

  always_comb begin
    latch_vec = '0;
    case (i_request_select)
      SEL_FETCH_DATA: latch_vec = i_latch_fetch_data;
      SEL_FETCH_CTRL: latch_vec = i_latch_fetch_ctrl;
      SEL_DECO_DATA:  latch_vec = i_latch_deco_data;
      SEL_DECO_CTRL:  latch_vec = i_latch_deco_ctrl;
      SEL_EXEC_DATA:  latch_vec = i_latch_exec_data;
      SEL_EXEC_CTRL:  latch_vec = i_latch_exec_ctrl;
      SEL_MEM_DATA:   latch_vec = i_latch_mem_data;
      SEL_MEM_CTRL:   latch_vec = i_latch_mem_ctrl;
      default:        latch_vec = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    snap_d     = snap_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_request_select != SEL_IDLE) begin
          sel_d      = i_request_select;
          word_cnt_d = 2'd0;
          // Memory words are not captured here: their synchronous read lands
          // exactly in the single SEND cycle and is passed straight through.
          case (req_new.src)
            SRC_GPR:   snap_d = {i_reg_data, {(NB_LATCH-NB_REG){1'b0}}};
            SRC_PC:    snap_d = {i_pc, {(NB_LATCH-NB_REG){1'b0}}};
            SRC_LATCH: snap_d = latch_vec;
            default:   snap_d = '0;
          endcase
          state_d = (req_new.n != 2'd0) ? ST_SEND : ST_EOD;
        end
      end
      ST_SEND: begin
        snap_d     = snap_q << NB_CONTROL_FRAME;
        word_cnt_d = word_cnt_q + 2'd1;
        if (word_cnt_q == req_cur.n - 2'd1) begin
          state_d = ST_EOD;
        end
      end
      ST_EOD:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= SEL_IDLE;
      snap_q     <= '0;
      word_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      snap_q     <= snap_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_comb begin
    o_frame = '0;
    if (state_q == ST_SEND) begin
      case (req_cur.src)
        SRC_DMEM: o_frame = i_mem_data;
        SRC_IMEM: o_frame = i_instr_mem_data;
        default:  o_frame = snap_q[NB_LATCH-1 -: NB_CONTROL_FRAME];
      endcase
    end
  end

  assign o_eod  = (state_q == ST_EOD);
  assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_debug_frame_writer.sv
// Bench for debug_frame_writer: directed scenarios plus randomized requests
// checked against a word-list model of each response.
module tb_debug_frame_writer;

  logic        clk;
  logic        rst;
  logic [5:0]  sel;
  logic [4:0]  reg_addr;
  logic [31:0] gpr [32];
  logic [31:0] reg_data;
  logic [31:0] pc;
  logic [31:0] dmem;
  logic [31:0] imem;
  logic [95:0] latch [8];
  logic [31:0] frame;
  logic        eod;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  assign reg_data = gpr[reg_addr];

  debug_frame_writer dut (
    .i_clock            (clk),
    .i_reset            (rst),
    .i_request_select   (sel),
    .o_reg_addr         (reg_addr),
    .i_reg_data         (reg_data),
    .i_pc               (pc),
    .i_mem_data         (dmem),
    .i_instr_mem_data   (imem),
    .i_latch_fetch_data (latch[0]),
    .i_latch_fetch_ctrl (latch[1]),
    .i_latch_deco_data  (latch[2]),
    .i_latch_deco_ctrl  (latch[3]),
    .i_latch_exec_data  (latch[4]),
    .i_latch_exec_ctrl  (latch[5]),
    .i_latch_mem_data   (latch[6]),
    .i_latch_mem_ctrl   (latch[7]),
    .o_frame            (frame),
    .o_eod              (eod),
    .o_busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic scramble();
    for (int i = 0; i < 32; i++) gpr[i] = $urandom;
    for (int i = 0; i < 8; i++) latch[i] = {$urandom, $urandom, $urandom};
    pc   = $urandom;
    dmem = $urandom;
    imem = $urandom;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    sel = 6'h3f;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (frame !== 32'h0) begin n_err++; $display("FAIL reset_frame: got %h expected 0", frame); end
    n_vec++; if (eod !== 1'b0) begin n_err++; $display("FAIL reset_eod: got %b expected 0", eod); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_gpr();
    @(negedge clk);
    gpr[5] = 32'hDEADBEEF;
    sel = 6'b000101;
    #1;
    n_vec++; if (reg_addr !== 5'd5) begin n_err++; $display("FAIL gpr_addr: got %0d expected 5", reg_addr); end
    @(negedge clk);
    sel = 6'h3f;
    gpr[5] = 32'h0;
    #1;
    n_vec++; if (frame !== 32'hDEADBEEF) begin n_err++; $display("FAIL gpr_frame: got %h expected deadbeef", frame); end
    @(negedge clk); #1;
    n_vec++; if (eod !== 1'b1) begin n_err++; $display("FAIL gpr_eod: got %b expected 1", eod); end
    @(negedge clk); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL gpr_idle: busy %b expected 0", busy); end
  endtask

  task automatic test_latch();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h11111111; exp_w[1] = 32'h22222222; exp_w[2] = 32'h33333333;
    @(negedge clk);
    latch[4] = 96'h11111111_22222222_33333333;
    sel = 6'b101000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sel = 6'h3f;
      latch[4] = {$urandom, $urandom, $urandom};
      #1;
      n_vec++; if (frame !== exp_w[k]) begin n_err++; $display("FAIL latch_word%0d: got %h expected %h", k, frame, exp_w[k]); end
    end
    @(negedge clk); #1;
    n_vec++; if (eod !== 1'b1 || frame !== 32'h0) begin n_err++; $display("FAIL latch_eod: eod %b frame %h expected 1/0", eod, frame); end
  endtask

  task automatic test_dmem();
    @(negedge clk);
    dmem = 32'h0;
    sel = 6'b100000;
    @(negedge clk);
    sel = 6'h3f;
    dmem = 32'hCAFE0001;
    #1;
    n_vec++; if (frame !== 32'hCAFE0001) begin n_err++; $display("FAIL dmem_frame: got %h expected cafe0001", frame); end
    @(negedge clk);
    dmem = 32'h0;
    #1;
    n_vec++; if (eod !== 1'b1) begin n_err++; $display("FAIL dmem_eod: got %b expected 1", eod); end
  endtask

  task automatic test_invalid();
    @(negedge clk);
    sel = 6'b101100;
    @(negedge clk);
    sel = 6'h3f;
    #1;
    n_vec++; if (eod !== 1'b1 || frame !== 32'h0) begin n_err++; $display("FAIL invalid_eod: eod %b frame %h expected 1/0", eod, frame); end
    @(negedge clk); #1;
    n_vec++; if (busy !== 1'b0 || eod !== 1'b0) begin n_err++; $display("FAIL invalid_idle: busy %b eod %b expected 0/0", busy, eod); end
  endtask

  task automatic test_abort();
    logic [95:0] v;
    logic [31:0] pcv;
    v = {$urandom, $urandom, $urandom};
    @(negedge clk);
    latch[5] = v;
    sel = 6'b101001;
    @(negedge clk);
    sel = 6'b100010;
    pc = $urandom;
    #1;
    n_vec++; if (frame !== v[95:64]) begin n_err++; $display("FAIL abort_word0: got %h expected %h", frame, v[95:64]); end
    @(negedge clk);
    sel = 6'h3f;
    rst = 1'b1;
    #1;
    n_vec++; if (frame !== v[63:32]) begin n_err++; $display("FAIL abort_ignore: got %h expected %h", frame, v[63:32]); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (frame !== 32'h0 || busy !== 1'b0) begin n_err++; $display("FAIL abort_reset: frame %h busy %b expected 0/0", frame, busy); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_vec++; if (eod !== 1'b0) begin n_err++; $display("FAIL abort_no_eod: got %b expected 0", eod); end
    end
    pcv = $urandom;
    @(negedge clk);
    pc = pcv;
    sel = 6'b100010;
    @(negedge clk);
    sel = 6'h3f;
    pc = ~pcv;
    #1;
    n_vec++; if (frame !== pcv) begin n_err++; $display("FAIL abort_pc: got %h expected %h", frame, pcv); end
    @(negedge clk); #1;
    n_vec++; if (eod !== 1'b1) begin n_err++; $display("FAIL abort_pc_eod: got %b expected 1", eod); end
  endtask

  // Model: each request expands to an ordered list of words taken from the
  // source as it stood in the request cycle; memory words come from the
  // cycle after the request; invalid codes produce an empty list.
  task automatic test_random();
    logic [31:0] exp_q [$];
    logic [95:0] vec;
    logic [5:0]  code;
    int          kind;
    int          is_mem;
    int          idx;
    for (int it = 0; it < 80; it++) begin
      @(negedge clk);
      scramble();
      exp_q.delete();
      is_mem = 0;
      kind = $urandom_range(0, 5);
      case (kind)
        0: begin
          idx = $urandom_range(0, 31);
          code = 6'(idx);
          exp_q.push_back(gpr[idx]);
        end
        1: begin code = 6'b100000; is_mem = 1; end
        2: begin code = 6'b100001; is_mem = 2; end
        3: begin code = 6'b100010; exp_q.push_back(pc); end
        4: begin
          idx = $urandom_range(0, 7);
          code = 6'(36 + idx);
          vec = latch[idx];
          exp_q.push_back(vec[95:64]);
          exp_q.push_back(vec[63:32]);
          exp_q.push_back(vec[31:0]);
        end
        default: begin
          idx = $urandom_range(0, 19);
          code = (idx == 19) ? 6'b100011 : 6'(44 + idx);
        end
      endcase
      sel = code;
      #1;
      n_vec++; if (busy !== 1'b0 || frame !== 32'h0) begin n_err++; $display("FAIL rnd_idle it%0d: busy %b frame %h expected 0/0", it, busy, frame); end
      if (kind == 0) begin
        n_vec++; if (reg_addr !== code[4:0]) begin n_err++; $display("FAIL rnd_addr it%0d: got %0d expected %0d", it, reg_addr, code[4:0]); end
      end
      if (is_mem != 0) begin
        @(negedge clk);
        sel = 6'h3f;
        scramble();
        #1;
        n_vec++;
        if (frame !== ((is_mem == 1) ? dmem : imem)) begin
          n_err++; $display("FAIL rnd_mem it%0d: got %h expected %h", it, frame, (is_mem == 1) ? dmem : imem);
        end
      end else begin
        for (int k = 0; k < exp_q.size(); k++) begin
          @(negedge clk);
          sel = 6'h3f;
          scramble();
          #1;
          n_vec++; if (frame !== exp_q[k] || busy !== 1'b1 || eod !== 1'b0) begin
            n_err++; $display("FAIL rnd_word it%0d k%0d: frame %h busy %b eod %b expected %h/1/0", it, k, frame, busy, eod, exp_q[k]);
          end
        end
      end
      @(negedge clk);
      sel = 6'h3f;
      scramble();
      #1;
      n_vec++; if (eod !== 1'b1 || frame !== 32'h0 || busy !== 1'b1) begin
        n_err++; $display("FAIL rnd_eod it%0d: eod %b frame %h busy %b expected 1/0/1", it, eod, frame, busy);
      end
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk); #1;
        n_vec++; if (busy !== 1'b0 || eod !== 1'b0) begin n_err++; $display("FAIL rnd_gap it%0d: busy %b eod %b expected 0/0", it, busy, eod); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    sel = 6'h3f;
    scramble();
    test_reset();
    test_gpr();
    test_latch();
    test_dmem();
    test_invalid();
    test_abort();
    test_random();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
